exp_table_loader: RTL and testbench



---
 rtl/exp_table_loader.sv | 145 ++++++++++++++
 tb/tb_exp_table_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_table_loader.sv
// Loads the exp(x*sigma) sample stream into a table indexed by x, sums the samples,
// and serves fixed-latency lookups once the table is complete.
module exp_table_loader #(
    parameter int          X_MIN      = -307,
    parameter int          X_MAX      = 280,
    parameter int unsigned PATH_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned SUM_WIDTH  = 28,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iBuild,
    output logic                  oGenStart,
    input  logic [DATA_WIDTH-1:0] iGenData,
    input  logic [PATH_WIDTH-1:0] iGenAddr,
    input  logic                  iGenValid,
    input  logic                  iGenDone,
    input  logic                  iRdEn,
    input  logic [PATH_WIDTH-1:0] iRdAddr,
    output logic [DATA_WIDTH-1:0] oRdData,
    output logic                  oRdValid,
    output logic [SUM_WIDTH-1:0]  oSum,
    output logic                  oReady,
    output logic                  oBusy,
    output logic                  oError
);
    localparam int unsigned DEPTH    = unsigned'(X_MAX - X_MIN + 1);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned OFF_W    = PATH_WIDTH + 1;
    localparam int          LAST_OFF = X_MAX - X_MIN;

    typedef enum logic [1:0] {IDLE, REQ, FILL, READY} state_t;

    state_t                  state;
    logic [SUM_WIDTH-1:0]    acc;
    logic [SUM_WIDTH-1:0]    acc_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [CNT_W-1:0]        tmo;
    logic [PATH_WIDTH-1:0]   exp_addr;
    logic                    done_q;
    logic                    smp;
    logic                    done_edge;
    logic                    addr_err;

    logic signed [OFF_W-1:0] wr_off;
    logic signed [OFF_W-1:0] rd_off;
    logic                    wr_in;
    logic                    rd_in;
    logic                    wr_en;
    logic                    rd_req;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    rd_v1;
    logic                    rd_in1;

    // Offsets are one bit wider than x so out-of-range addresses never alias into the table
    assign wr_off    = OFF_W'($signed(iGenAddr)) - OFF_W'(X_MIN);
    assign rd_off    = OFF_W'($signed(iRdAddr)) - OFF_W'(X_MIN);
    assign wr_in     = !wr_off[OFF_W-1] && (wr_off <= OFF_W'(LAST_OFF));
    assign rd_in     = !rd_off[OFF_W-1] && (rd_off <= OFF_W'(LAST_OFF));

    assign smp       = (state == FILL) && iGenValid;
    assign acc_nxt   = acc + (smp ? SUM_WIDTH'(iGenData) : '0);
    assign cnt_nxt   = cnt + CNT_W'(smp);
    assign addr_err  = smp && (iGenAddr != exp_addr);
    assign done_edge = iGenDone && !done_q;
    assign wr_en     = smp && wr_in && !RST;
    assign rd_req    = (state == READY) && iRdEn;

    // Table storage: one write port, one registered read port
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_off[IDX_W-1:0]] <= iGenData;
        if (rd_req && rd_in) ram_q <= mem[rd_off[IDX_W-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_v1    <= 1'b0;
            rd_in1   <= 1'b0;
            oRdValid <= 1'b0;
            oRdData  <= '0;
        end else begin
            rd_v1    <= rd_req;
            rd_in1   <= rd_in;
            oRdValid <= rd_v1;
            oRdData  <= (rd_v1 && rd_in1) ? ram_q : '0;
        end
    end

    // Build sequencing: a build request restarts from any state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            oGenStart <= 1'b0;
            oBusy     <= 1'b0;
            oReady    <= 1'b0;
            oError    <= 1'b0;
            oSum      <= '0;
            acc       <= '0;
            cnt       <= '0;
            tmo       <= '0;
            exp_addr  <= PATH_WIDTH'(X_MIN);
            done_q    <= 1'b0;
        end else begin
            done_q    <= iGenDone;
            oGenStart <= 1'b0;
            if (iBuild) begin
                state     <= REQ;
                oGenStart <= 1'b1;
                oBusy     <= 1'b1;
                oReady    <= 1'b0;
                oError    <= 1'b0;
                oSum      <= '0;
                acc       <= '0;
                cnt       <= '0;
                tmo       <= '0;
                exp_addr  <= PATH_WIDTH'(X_MIN);
            end else begin
                case (state)
                    REQ: state <= FILL;
                    FILL: begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        tmo <= tmo + CNT_W'(1);
                        if (smp) exp_addr <= exp_addr + PATH_WIDTH'(1);
                        if (addr_err) oError <= 1'b1;
                        if (done_edge || (tmo == CNT_W'(TIMEOUT - 1))) begin
                            state  <= READY;
                            oBusy  <= 1'b0;
                            oReady <= 1'b1;
                            oSum   <= acc_nxt;
                            if (!done_edge || addr_err || (cnt_nxt != CNT_W'(DEPTH)))
                                oError <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exp_table_loader.sv
// Randomized bench for exp_table_loader: a reference table/sum model drives a lookup scoreboard.
module tb_exp_table_loader;
    localparam int     X_MIN   = -307;
    localparam int     X_MAX   = 280;
    localparam int     DEPTH   = X_MAX - X_MIN + 1;
    localparam int     NO_X    = 9999;
    localparam longint SUM_MOD = 64'h1000_0000;

    typedef struct {
        int data;
        int cyc;
    } rd_exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iBuild;
    logic        oGenStart;
    logic [17:0] iGenData;
    logic [9:0]  iGenAddr;
    logic        iGenValid;
    logic        iGenDone;
    logic        iRdEn;
    logic [9:0]  iRdAddr;
    logic [17:0] oRdData;
    logic        oRdValid;
    logic [27:0] oSum;
    logic        oReady;
    logic        oBusy;
    logic        oError;

    int      pass_cnt = 0;
    int      chk_cnt  = 0;
    int      cyc      = 0;
    int      gs_cnt   = 0;
    int      ref_tab [DEPTH];
    rd_exp_t rd_q [$];
    bit      m_ready;
    bit      m_err;
    longint  m_sum;
    int      m_cnt;
    int      m_exp;

    exp_table_loader dut (
        .CLK(CLK), .RST(RST), .iBuild(iBuild), .oGenStart(oGenStart),
        .iGenData(iGenData), .iGenAddr(iGenAddr), .iGenValid(iGenValid), .iGenDone(iGenDone),
        .iRdEn(iRdEn), .iRdAddr(iRdAddr), .oRdData(oRdData), .oRdValid(oRdValid),
        .oSum(oSum), .oReady(oReady), .oBusy(oBusy), .oError(oError)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard monitor: every lookup result must match the oldest pending expectation
    always @(negedge CLK) begin
        if (oGenStart === 1'b1) gs_cnt++;
        if (oRdValid === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL rd_unexpected: oRdValid=1 data=%0d with no lookup pending", oRdData);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("rd_data", longint'(oRdData), e.data);
                check("rd_latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int ref_rd(input int x);
        return (x >= X_MIN && x <= X_MAX) ? ref_tab[x - X_MIN] : 0;
    endfunction

    task automatic set_rd(input int x);
        iRdEn   = 1'b1;
        iRdAddr = 10'(x);
        if (m_ready) rd_q.push_back('{data: ref_rd(x), cyc: cyc + 2});
    endtask

    task automatic rd_burst(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) == 0) set_rd(int'($urandom_range(1023)) - 512);
            else set_rd(X_MIN + int'($urandom_range(DEPTH - 1)));
            tick();
            iRdEn = 1'b0;
            if ($urandom_range(3) == 0) tick();
        end
    endtask

    task automatic start_build(input bit with_rd, input int rd_x);
        int g0;
        g0 = gs_cnt;
        iBuild = 1'b1;
        if (with_rd) set_rd(rd_x);
        tick();
        iBuild  = 1'b0;
        iRdEn   = 1'b0;
        m_ready = 1'b0;
        check("gen_start_pulse", oGenStart, 1);
        check("busy_req", oBusy, 1);
        check("ready_low_req", oReady, 0);
        check("sum_clear_req", oSum, 0);
        tick();
        check("gen_start_drop", oGenStart, 0);
        check("gen_start_count", gs_cnt - g0, 1);
        m_sum = 0; m_cnt = 0; m_err = 1'b0; m_exp = X_MIN;
    endtask

    task automatic send(input int x, input int d, input bit done);
        iGenValid = 1'b1;
        iGenAddr  = 10'(x);
        iGenData  = 18'(d);
        iGenDone  = done;
        if (x != m_exp) m_err = 1'b1;
        if (x >= X_MIN && x <= X_MAX) ref_tab[x - X_MIN] = d;
        m_sum = (m_sum + longint'(d)) % SUM_MOD;
        m_cnt++;
        m_exp++;
        tick();
        iGenValid = 1'b0;
    endtask

    // Generator model: ascending x with random idle gaps; stops early at stop_x
    task automatic stream(input int skip_x, input int stop_x, input bit rnd, input bit same);
        iGenDone = 1'b0;
        for (int x = X_MIN; x <= X_MAX; x++) begin
            if (x == stop_x) return;
            if (x == skip_x) continue;
            if ($urandom_range(7) == 0) begin
                iGenData = 18'($urandom);
                iGenAddr = 10'($urandom);
                iRdEn    = 1'($urandom);
                iRdAddr  = 10'($urandom);
                tick();
                iRdEn = 1'b0;
            end
            send(x, rnd ? int'($urandom_range(262143)) : x + 400, same && (x == X_MAX));
        end
        if (!same) begin
            iGenDone = 1'b1;
            tick();
        end
    endtask

    task automatic finish_build(input string tag);
        check({tag, "_ready"}, oReady, 1);
        check({tag, "_busy"}, oBusy, 0);
        check({tag, "_error"}, oError, longint'(m_err || (m_cnt != DEPTH)));
        check({tag, "_sum"}, oSum, m_sum);
        m_ready = 1'b1;
    endtask

    initial begin
        int n;
        RST = 1'b1; iBuild = 1'b0; iGenData = '0; iGenAddr = '0; iGenValid = 1'b0;
        iGenDone = 1'b0; iRdEn = 1'b0; iRdAddr = '0; m_ready = 1'b0;
        repeat (3) tick();
        check("rst_ready", oReady, 0);
        check("rst_busy", oBusy, 0);
        check("rst_error", oError, 0);
        check("rst_gen_start", oGenStart, 0);
        check("rst_sum", oSum, 0);
        check("rst_rd_valid", oRdValid, 0);
        check("rst_rd_data", oRdData, 0);
        RST = 1'b0;

        // Lookups in IDLE must produce nothing
        for (int i = 0; i < 4; i++) begin
            iRdEn = 1'b1; iRdAddr = 10'($urandom); tick();
        end
        iRdEn = 1'b0;

        start_build(1'b0, 0);
        stream(NO_X, NO_X, 1'b0, 1'b0);
        finish_build("b1");

        set_rd(-307); tick();
        set_rd(0);    tick();
        set_rd(280);  tick();
        set_rd(281);  tick();
        set_rd(-308); tick();
        iRdEn = 1'b0;
        repeat (3) tick();
        check("oob_error_kept", oError, 0);
        check("oob_ready_kept", oReady, 1);
        rd_burst(30);

        // Reset lands while x=0 is presented; later samples must not write
        start_build(1'b0, 0);
        stream(NO_X, 0, 1'b1, 1'b0);
        RST = 1'b1; iGenValid = 1'b1; iGenAddr = 10'(0); iGenData = 18'($urandom);
        tick();
        RST = 1'b0;
        m_ready = 1'b0;
        check("rst_fill_busy", oBusy, 0);
        check("rst_fill_ready", oReady, 0);
        check("rst_fill_sum", oSum, 0);
        check("rst_fill_error", oError, 0);
        for (int x = 1; x <= X_MAX; x++) begin
            iGenValid = 1'b1; iGenAddr = 10'(x); iGenData = 18'($urandom); tick();
        end
        iGenValid = 1'b0; iGenDone = 1'b1; tick(); iGenDone = 1'b0;
        check("rst_idle_busy", oBusy, 0);
        check("rst_idle_ready", oReady, 0);

        // Skipped sample: error flagged, skipped entry keeps its earlier value
        start_build(1'b0, 0);
        stream(5, NO_X, 1'b1, 1'b0);
        finish_build("b3");
        set_rd(5); tick(); iRdEn = 1'b0;
        rd_burst(20);

        // Restart mid-fill, then a build whose done coincides with the last sample
        start_build(1'b0, 0);
        stream(NO_X, int'($urandom_range(200)) - 100, 1'b1, 1'b0);
        start_build(1'b0, 0);
        stream(NO_X, NO_X, 1'b1, 1'b1);
        finish_build("b4");
        rd_burst(20);

        // Lookups accepted in READY complete even as a rebuild begins
        set_rd(X_MAX); tick();
        start_build(1'b1, X_MIN);
        stream(NO_X, NO_X, 1'b1, 1'b0);
        finish_build("b5");
        rd_burst(20);

        // Stale done level with no samples: only the timeout ends the fill
        iGenDone = 1'b1;
        repeat (3) tick();
        start_build(1'b0, 0);
        n = 0;
        while (!oReady && n < 1100) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 1024);
        check("tmo_ready", oReady, 1);
        check("tmo_error", oError, 1);
        check("tmo_sum", oSum, 0);
        m_ready = 1'b1;
        rd_burst(10);
        iGenDone = 1'b0;

        repeat (5) tick();
        check("rd_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
